hazard_unit_sb: RTL and testbench

- Parametrised successor to the pipeline hazard unit for the 5-stage (F/D/E/M/W) filter-GPU core.
- Adds N configurable source operands with M/W forwarding and load-use stalls.
- Adds a one-entry scoreboard for a non-pipelined multi-cycle unit (RAW, WAW and structural stalls), branch flush, and a saturating stall-cycle performance counter.
- Sits beside the datapath; purely control outputs.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/mul_scoreboard.sv | 39 +++
 rtl/hazard_unit_sb.sv | 113 +++++++++++
 tb/tb_hazard_unit_sb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard unit: forwarding select encoding
// and the address comparator used by every hazard check.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam int DEF_REG_AW = 4;
  // Comparator operands are widened to this so one function serves any REG_AW.
  localparam int ADDR_MAX = 16;

  function automatic logic addr_hit(input logic [ADDR_MAX-1:0] src,
                                    input logic                used,
                                    input logic [ADDR_MAX-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/mul_scoreboard.sv
// One-entry scoreboard for the non-pipelined multi-cycle unit: counts down
// from issue to the regfile write cycle and remembers the destination.
module mul_scoreboard #(
  parameter int REG_AW  = 4,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_wa,
  output logic              busy,
  output logic              busy2,
  output logic              write_w,
  output logic [REG_AW-1:0] wa
);

  logic [3:0]        pend_cnt;
  logic [REG_AW-1:0] pend_wa;

  // A new issue overrides the countdown; structural stalls guarantee the
  // previous op is already in its write cycle or finished when that happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt <= 4'd0;
      pend_wa  <= '0;
    end else if (issue) begin
      pend_cnt <= 4'(MUL_LAT);
      pend_wa  <= issue_wa;
    end else if (pend_cnt != 4'd0) begin
      pend_cnt <= pend_cnt - 4'd1;
    end
  end

  assign busy    = (pend_cnt != 4'd0);
  assign busy2   = (pend_cnt >= 4'd2);
  assign write_w = (pend_cnt == 4'd1);
  assign wa      = pend_wa;

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: per-source M/W forwarding, load-use and multi-cycle
// unit stalls, branch flush and a saturating stall-cycle counter.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_SRC = 3,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] RAD,
  input  logic [NUM_SRC-1:0]        UseD,
  input  logic [REG_AW-1:0]         WA3D,
  input  logic                      RegWriteD,
  input  logic                      MultiD,
  input  logic [NUM_SRC*REG_AW-1:0] RAE,
  input  logic [REG_AW-1:0]         WA3E,
  input  logic                      RegWriteE,
  input  logic                      MemtoRegE,
  input  logic                      MultiE,
  input  logic                      BranchTakenE,
  input  logic [REG_AW-1:0]         WA3M,
  input  logic                      RegWriteM,
  input  logic [REG_AW-1:0]         WA3W,
  input  logic                      RegWriteW,
  input  logic                      StatClr,
  output logic [2*NUM_SRC-1:0]      ForwardE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      MulWriteW,
  output logic [REG_AW-1:0]         MulWA,
  output logic                      MulBusy,
  output logic [CNT_W-1:0]          StallCount
);

  logic               issue;
  logic               mul_busy2;
  logic               ld_stall;
  logic               mul_stall;
  logic               stall;
  logic [NUM_SRC-1:0] e_dst_hit;
  logic [NUM_SRC-1:0] pend_hit;
  logic [CNT_W-1:0]   stall_count_reg;

  assign issue = MultiE & RegWriteE;

  mul_scoreboard #(
    .REG_AW  (REG_AW),
    .MUL_LAT (MUL_LAT)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .issue    (issue),
    .issue_wa (WA3E),
    .busy     (MulBusy),
    .busy2    (mul_busy2),
    .write_w  (MulWriteW),
    .wa       (MulWA)
  );

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] rad_i;
      logic [REG_AW-1:0] rae_i;
      fwd_sel_t          sel;

      assign rad_i = RAD[gi*REG_AW +: REG_AW];
      assign rae_i = RAE[gi*REG_AW +: REG_AW];

      always_comb begin
        sel = FWD_RF;
        if (addr_hit(ADDR_MAX'(rae_i), RegWriteM, ADDR_MAX'(WA3M)))
          sel = FWD_M;
        else if (addr_hit(ADDR_MAX'(rae_i), RegWriteW, ADDR_MAX'(WA3W)))
          sel = FWD_W;
      end

      assign ForwardE[2*gi +: 2] = sel;
      // Same D-reads-E-destination compare feeds both load-use and RAW-at-issue.
      assign e_dst_hit[gi] = addr_hit(ADDR_MAX'(rad_i), UseD[gi], ADDR_MAX'(WA3E));
      assign pend_hit[gi]  = addr_hit(ADDR_MAX'(rad_i), UseD[gi], ADDR_MAX'(MulWA));
    end
  endgenerate

  assign ld_stall  = MemtoRegE & RegWriteE & (|e_dst_hit);
  // At pend_cnt==1 the regfile write-before-read covers the reader, so only busy2 stalls.
  assign mul_stall = (mul_busy2 & (|pend_hit))
                   | (issue & (|e_dst_hit))
                   | (RegWriteD & mul_busy2 & (WA3D == MulWA))
                   | (MultiD & (mul_busy2 | issue));
  assign stall     = ld_stall | mul_stall;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall | BranchTakenE;
  assign FlushD = BranchTakenE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_reg <= '0;
    else if (StatClr)
      stall_count_reg <= '0;
    else if (stall && (stall_count_reg != '1))
      stall_count_reg <= stall_count_reg + CNT_W'(1);
  end

  assign StallCount = stall_count_reg;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// every cycle against a cycle-count based behavioural model.
module tb_hazard_unit_sb;
  localparam int AW  = 4;
  localparam int NS  = 3;
  localparam int LAT = 4;
  localparam int CW  = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NS*AW-1:0] RAD = '0, RAE = '0;
  logic [NS-1:0]  UseD = '0;
  logic [AW-1:0]  WA3D = '0, WA3E = '0, WA3M = '0, WA3W = '0;
  logic           RegWriteD = 0, MultiD = 0, RegWriteE = 0, MemtoRegE = 0, MultiE = 0;
  logic           BranchTakenE = 0, RegWriteM = 0, RegWriteW = 0, StatClr = 0;
  logic [2*NS-1:0] ForwardE;
  logic           StallF, StallD, FlushD, FlushE, MulWriteW, MulBusy;
  logic [AW-1:0]  MulWA;
  logic [CW-1:0]  StallCount;

  hazard_unit_sb #(.REG_AW(AW), .NUM_SRC(NS), .MUL_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .RAD(RAD), .UseD(UseD), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MultiD(MultiD), .RAE(RAE), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MultiE(MultiE),
    .BranchTakenE(BranchTakenE), .WA3M(WA3M), .RegWriteM(RegWriteM),
    .WA3W(WA3W), .RegWriteW(RegWriteW), .StatClr(StatClr),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .MulWriteW(MulWriteW), .MulWA(MulWA), .MulBusy(MulBusy),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the multi op is tracked by the absolute cycle of its regfile write.
  int            cyc = 0;
  int            wr_cyc = -1;
  logic [AW-1:0] m_wa = '0;
  int            m_cnt = 0;
  logic [2*NS-1:0] e_fwd;
  logic          e_stall, e_fd, e_fe, e_mw, e_mb;

  function automatic logic [AW-1:0] src(input logic [NS*AW-1:0] v, input int i);
    return v[i*AW +: AW];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    logic busy2;
    logic st;
    logic [1:0] f;
    busy2 = (wr_cyc > cyc);
    st = 1'b0;
    for (int i = 0; i < NS; i++) begin
      f = 2'b00;
      if (RegWriteM && WA3M == src(RAE, i)) f = 2'b10;
      else if (RegWriteW && WA3W == src(RAE, i)) f = 2'b01;
      e_fwd[2*i +: 2] = f;
      if (UseD[i]) begin
        if (RegWriteE && (MemtoRegE || MultiE) && WA3E == src(RAD, i)) st = 1'b1;
        if (busy2 && src(RAD, i) == m_wa) st = 1'b1;
      end
    end
    if (RegWriteD && busy2 && WA3D == m_wa) st = 1'b1;
    if (MultiD && (busy2 || (MultiE && RegWriteE))) st = 1'b1;
    e_stall = st;
    e_fd    = BranchTakenE;
    e_fe    = st || BranchTakenE;
    e_mw    = (wr_cyc == cyc);
    e_mb    = (wr_cyc >= cyc);
  endtask

  task automatic model_advance();
    model_eval();
    if (StatClr) m_cnt = 0;
    else if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    if (MultiE && RegWriteE) begin
      wr_cyc = cyc + LAT;
      m_wa   = WA3E;
    end
    cyc++;
  endtask

  task automatic model_reset();
    wr_cyc = -1;
    m_wa   = '0;
    m_cnt  = 0;
  endtask

  task automatic compare_all();
    model_eval();
    check("ForwardE", 32'(ForwardE), 32'(e_fwd));
    check("StallF", 32'(StallF), 32'(e_stall));
    check("StallD", 32'(StallD), 32'(e_stall));
    check("FlushD", 32'(FlushD), 32'(e_fd));
    check("FlushE", 32'(FlushE), 32'(e_fe));
    check("MulWriteW", 32'(MulWriteW), 32'(e_mw));
    check("MulBusy", 32'(MulBusy), 32'(e_mb));
    check("MulWA", 32'(MulWA), 32'(m_wa));
    check("StallCount", 32'(StallCount), 32'(m_cnt));
  endtask

  // Called just after an edge with new inputs applied: compare, then cross the next edge.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    if (!reset) model_advance();
    #1;
  endtask

  task automatic idle();
    RAD = '0; RAE = '0; UseD = '0; WA3D = '0; WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteD = 0; MultiD = 0; RegWriteE = 0; MemtoRegE = 0; MultiE = 0;
    BranchTakenE = 0; RegWriteM = 0; RegWriteW = 0; StatClr = 0;
  endtask

  task automatic set_rad(input int i, input logic [AW-1:0] v);
    RAD[i*AW +: AW] = v;
  endtask

  task automatic set_rae(input int i, input logic [AW-1:0] v);
    RAE[i*AW +: AW] = v;
  endtask

  task automatic load_use_setup();
    idle();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd7; set_rad(2, 4'd7); UseD = 3'b100;
  endtask

  initial begin
    idle();
    #2;
    check("reset_ForwardE", 32'(ForwardE), 32'h0);
    check("reset_StallD", 32'(StallD), 32'h0);
    check("reset_MulBusy", 32'(MulBusy), 32'h0);
    check("reset_StallCount", 32'(StallCount), 32'h0);
    compare_all();
    #1 reset = 1'b0;
    tick();

    // Forwarding priority
    set_rae(0, 4'd3); set_rae(1, 4'd5); set_rae(2, 4'd12);
    WA3M = 4'd3; RegWriteM = 1; WA3W = 4'd3; RegWriteW = 1;
    #1 check("fwd_M_over_W", 32'(ForwardE), 32'b00_00_10);
    tick();
    WA3W = 4'd5;
    #1 check("fwd_M_and_W", 32'(ForwardE), 32'b00_01_10);
    tick();
    WA3W = 4'd3; RegWriteM = 0;
    #1 check("fwd_W_only", 32'(ForwardE), 32'b00_00_01);
    tick();

    // Load-use
    load_use_setup();
    #1 check("ld_stall", 32'({StallF, StallD, FlushE}), 32'b111);
    tick();
    UseD = 3'b000;
    #1 check("ld_unused", 32'({StallF, StallD, FlushE}), 32'b000);
    tick();

    // Multi RAW through the whole countdown
    idle();
    MultiE = 1; RegWriteE = 1; WA3E = 4'd9; set_rad(0, 4'd9); UseD = 3'b001;
    #1 check("mul_raw_issue", 32'(StallD), 32'h1);
    tick();
    MultiE = 0; RegWriteE = 0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      check($sformatf("mul_raw_stall_c%0d", k), 32'(StallD), 32'(k <= 3));
      check($sformatf("mul_raw_write_c%0d", k), 32'(MulWriteW), 32'(k == 4));
      check($sformatf("mul_raw_busy_c%0d", k), 32'(MulBusy), 32'(k <= 4));
      if (k == 4) check("mul_raw_wa", 32'(MulWA), 32'd9);
      tick();
    end

    // Structural / WAW while pend_cnt==3, then branch over a load-use stall
    idle();
    MultiE = 1; RegWriteE = 1; WA3E = 4'd6;
    tick();
    idle();
    tick();
    MultiD = 1;
    #1 check("structural", 32'(StallD), 32'h1);
    MultiD = 0; RegWriteD = 1; WA3D = 4'd6;
    #1 check("waw", 32'(StallD), 32'h1);
    WA3D = 4'd2;
    #1 check("no_waw", 32'(StallD), 32'h0);
    tick();
    load_use_setup();
    BranchTakenE = 1;
    #1 check("branch_flush", 32'({FlushD, FlushE}), 32'b11);
    tick();
    idle();
    #1 check("branch_keeps_mul", 32'(MulBusy), 32'h1);
    tick();
    tick();
    tick();

    // Stall counter
    StatClr = 1;
    tick();
    StatClr = 0;
    #1 check("cnt_clear0", 32'(StallCount), 32'h0);
    load_use_setup();
    repeat (5) tick();
    idle();
    #1 check("cnt_five", 32'(StallCount), 32'd5);
    StatClr = 1;
    tick();
    StatClr = 0;
    #1 check("cnt_clear", 32'(StallCount), 32'h0);

    // Asynchronous reset with an op in flight
    MultiE = 1; RegWriteE = 1; WA3E = 4'd11;
    tick();
    idle();
    tick();
    reset = 1;
    #1;
    check("rst_busy", 32'(MulBusy), 32'h0);
    check("rst_write", 32'(MulWriteW), 32'h0);
    check("rst_cnt", 32'(StallCount), 32'h0);
    model_reset();
    reset = 0;
    tick();
    MultiE = 1; RegWriteE = 1; WA3E = 4'd13;
    tick();
    idle();
    repeat (3) tick();
    #1 check("pre_rst_write", 32'(MulWriteW), 32'h1);
    reset = 1;
    #1 check("rst_write_async", 32'(MulWriteW), 32'h0);
    model_reset();
    reset = 0;
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) begin
        set_rad(i, 4'($urandom_range(0, 3)));
        set_rae(i, 4'($urandom_range(0, 3)));
      end
      UseD         = 3'($urandom);
      WA3D         = 4'($urandom_range(0, 3));
      WA3E         = 4'($urandom_range(0, 3));
      WA3M         = 4'($urandom_range(0, 3));
      WA3W         = 4'($urandom_range(0, 3));
      RegWriteD    = 1'($urandom);
      MultiD       = ($urandom_range(0, 3) == 0);
      RegWriteE    = 1'($urandom);
      MemtoRegE    = ($urandom_range(0, 3) == 0);
      MultiE       = ($urandom_range(0, 3) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      RegWriteM    = 1'($urandom);
      RegWriteW    = 1'($urandom);
      StatClr      = ($urandom_range(0, 127) == 0);
      if (wr_cyc > cyc) MultiE = 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
